// File: rtl/sram_fault_model_if.sv
// Purpose: memory-access and fault-configuration bus for sram_fault_model.
// Latency: n/a (signal bundle only).
// Backpressure: none; the memory accepts every access and config write.
// Ports: master drives cs/rwbar/ramaddr/ramin and cfg_*; slave returns ramout and flt_hits.
interface sram_fault_model_if #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 6,
    parameter int NUM_FAULTS = 2,
    parameter int HIT_W      = 16
);
    localparam int IDX_W = $clog2(NUM_FAULTS);
    localparam int BIT_W = $clog2(DATA_W);

    logic              cs;
    logic              rwbar;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramin;
    logic [DATA_W-1:0] ramout;
    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic [2:0]        cfg_type;
    logic [ADDR_W-1:0] cfg_vaddr;
    logic [BIT_W-1:0]  cfg_vbit;
    logic [ADDR_W-1:0] cfg_aaddr;
    logic [BIT_W-1:0]  cfg_abit;
    logic [HIT_W-1:0]  flt_hits;

    modport master (
        output cs, rwbar, ramaddr, ramin,
        output cfg_we, cfg_idx, cfg_type, cfg_vaddr, cfg_vbit, cfg_aaddr, cfg_abit,
        input  ramout, flt_hits
    );

    modport slave (
        input  cs, rwbar, ramaddr, ramin,
        input  cfg_we, cfg_idx, cfg_type, cfg_vaddr, cfg_vbit, cfg_aaddr, cfg_abit,
        output ramout, flt_hits
    );
endinterface

// File: rtl/sram_fault_model.sv
// Purpose: single-port SRAM model with programmable stuck-at/transition/CFin faults and a hit counter.
// Latency: read data one cycle after the address (registered address, combinational data out).
// Backpressure: none; every access completes in its cycle, config writes apply from the next cycle.
// Ports: clk, rst (sync, active-high), bus (slave side of sram_fault_model_if).
module sram_fault_model #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 6,
    parameter int NUM_FAULTS = 2,
    parameter int HIT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_fault_model_if.slave    bus
);
    localparam int IDX_W = $clog2(NUM_FAULTS);
    localparam int BIT_W = $clog2(DATA_W);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [BIT_W:0] DATA_W_L = (BIT_W+1)'(DATA_W);
    localparam logic [IDX_W:0] NUM_L    = (IDX_W+1)'(NUM_FAULTS);

    typedef enum logic [2:0] {
        F_NONE  = 3'd0,
        F_SA0   = 3'd1,
        F_SA1   = 3'd2,
        F_TF_UP = 3'd3,
        F_TF_DN = 3'd4,
        F_CFIN  = 3'd5
    } ftype_e;

    // Raw 3-bit type is kept so reserved codes simply match nothing.
    typedef struct packed {
        logic [2:0]        ftype;
        logic [ADDR_W-1:0] vaddr;
        logic [BIT_W-1:0]  vbit;
        logic [ADDR_W-1:0] aaddr;
        logic [BIT_W-1:0]  abit;
    } flt_t;

    flt_t              tbl [NUM_FAULTS];
    logic [DATA_W-1:0] ram [DEPTH];
    logic [ADDR_W-1:0] addr_reg;
    logic [HIT_W-1:0]  hits;

    logic [DATA_W-1:0]     rd_word;
    logic [DATA_W-1:0]     wr_old;
    logic [DATA_W-1:0]     wr_word;
    logic [NUM_FAULTS-1:0] cf_inv;
    logic                  rd_en;
    logic                  wr_en;
    logic                  hit;

    function automatic logic bit_ok(input logic [BIT_W-1:0] b);
        return {1'b0, b} < DATA_W_L;
    endfunction

    assign rd_en = bus.cs && bus.rwbar;
    assign wr_en = bus.cs && !bus.rwbar;

    // Read view: stored word with stuck-at victims forced, later entries win.
    always_comb begin
        rd_word = ram[addr_reg];
        for (int e = 0; e < NUM_FAULTS; e++) begin
            if (tbl[e].vaddr == addr_reg && bit_ok(tbl[e].vbit)) begin
                if (tbl[e].ftype == F_SA0)
                    rd_word[tbl[e].vbit] = 1'b0;
                else if (tbl[e].ftype == F_SA1)
                    rd_word[tbl[e].vbit] = 1'b1;
            end
        end
    end

    // Write view: SA/TF first in index order, then CFin inversions on top.
    always_comb begin
        wr_old  = ram[bus.ramaddr];
        wr_word = bus.ramin;
        cf_inv  = '0;
        for (int e = 0; e < NUM_FAULTS; e++) begin
            if (tbl[e].vaddr == bus.ramaddr && bit_ok(tbl[e].vbit)) begin
                case (tbl[e].ftype)
                    F_SA0:   wr_word[tbl[e].vbit] = 1'b0;
                    F_SA1:   wr_word[tbl[e].vbit] = 1'b1;
                    F_TF_UP: if (!wr_old[tbl[e].vbit] && wr_word[tbl[e].vbit])
                                 wr_word[tbl[e].vbit] = 1'b0;
                    F_TF_DN: if (wr_old[tbl[e].vbit] && !wr_word[tbl[e].vbit])
                                 wr_word[tbl[e].vbit] = 1'b1;
                    default: ;
                endcase
            end
        end
        for (int e = 0; e < NUM_FAULTS; e++) begin
            // Only a real transition of the aggressor bit sensitises the coupling.
            if (tbl[e].ftype == F_CFIN && bit_ok(tbl[e].vbit) && bit_ok(tbl[e].abit) &&
                tbl[e].aaddr == bus.ramaddr &&
                wr_old[tbl[e].abit] != bus.ramin[tbl[e].abit]) begin
                if (tbl[e].vaddr == bus.ramaddr)
                    wr_word[tbl[e].vbit] = ~wr_word[tbl[e].vbit];
                else
                    cf_inv[e] = 1'b1;
            end
        end
    end

    assign hit = (wr_en && (wr_word != bus.ramin || |cf_inv)) ||
                 (rd_en && rd_word != ram[addr_reg]);

    assign bus.ramout   = rd_en ? rd_word : '0;
    assign bus.flt_hits = hits;

    // Array contents survive reset; only the write is blocked during it.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            ram[bus.ramaddr] <= wr_word;
            for (int e = 0; e < NUM_FAULTS; e++) begin
                if (cf_inv[e])
                    ram[tbl[e].vaddr][tbl[e].vbit] <= ~ram[tbl[e].vaddr][tbl[e].vbit];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < NUM_FAULTS; e++)
                tbl[e] <= '0;
            addr_reg <= '0;
            hits     <= '0;
        end else begin
            if (bus.cs)
                addr_reg <= bus.ramaddr;
            if (bus.cfg_we && ({1'b0, bus.cfg_idx} < NUM_L))
                tbl[bus.cfg_idx] <= '{ftype: bus.cfg_type, vaddr: bus.cfg_vaddr,
                                      vbit: bus.cfg_vbit, aaddr: bus.cfg_aaddr,
                                      abit: bus.cfg_abit};
            if (hit && hits != '1)
                hits <= hits + 1'b1;
        end
    end
endmodule

// File: tb/tb_sram_fault_model.sv
// Purpose: self-checking bench for sram_fault_model using per-cycle vector tables.
// Latency: ramout checked mid-cycle, flt_hits checked after the edge via an expectation queue.
// Backpressure: none exercised; the memory never stalls.
module tb_sram_fault_model;
    localparam int DW = 8;
    localparam int AW = 6;
    localparam int NF = 2;
    localparam int HW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_fault_model_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_FAULTS(NF), .HIT_W(HW)) bus ();

    sram_fault_model #(.DATA_W(DW), .ADDR_W(AW), .NUM_FAULTS(NF), .HIT_W(HW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic       rst;
        logic       cs;
        logic       rw;
        logic [5:0] a;
        logic [7:0] d;
        logic       cw;
        logic       ci;
        logic [2:0] ty;
        logic [5:0] va;
        logic [2:0] vb;
        logic [5:0] aa;
        logic [2:0] ab;
        logic       co;
        logic [7:0] eo;
        logic [3:0] eh;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] exp_q[$];
    int         tag_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    function automatic vec_t base(input logic [3:0] eh);
        vec_t v;
        v = '{rst: 1'b0, cs: 1'b0, rw: 1'b0, a: 6'd0, d: 8'd0, cw: 1'b0, ci: 1'b0,
              ty: 3'd0, va: 6'd0, vb: 3'd0, aa: 6'd0, ab: 3'd0, co: 1'b0, eo: 8'd0, eh: eh};
        return v;
    endfunction

    function automatic vec_t wr(input logic [5:0] a, input logic [7:0] d, input logic [3:0] eh);
        vec_t v;
        v    = base(eh);
        v.cs = 1'b1;
        v.a  = a;
        v.d  = d;
        return v;
    endfunction

    function automatic vec_t rd(input logic [5:0] a, input logic co, input logic [7:0] eo,
                                input logic [3:0] eh);
        vec_t v;
        v    = base(eh);
        v.cs = 1'b1;
        v.rw = 1'b1;
        v.a  = a;
        v.co = co;
        v.eo = eo;
        return v;
    endfunction

    function automatic vec_t cfg(input logic ci, input logic [2:0] ty, input logic [5:0] va,
                                 input logic [2:0] vb, input logic [5:0] aa,
                                 input logic [2:0] ab, input logic [3:0] eh);
        vec_t v;
        v    = base(eh);
        v.cw = 1'b1;
        v.ci = ci;
        v.ty = ty;
        v.va = va;
        v.vb = vb;
        v.aa = aa;
        v.ab = ab;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst           = v.rst;
        bus.cs        = v.cs;
        bus.rwbar     = v.rw;
        bus.ramaddr   = v.a;
        bus.ramin     = v.d;
        bus.cfg_we    = v.cw;
        bus.cfg_idx   = v.ci;
        bus.cfg_type  = v.ty;
        bus.cfg_vaddr = v.va;
        bus.cfg_vbit  = v.vb;
        bus.cfg_aaddr = v.aa;
        bus.cfg_abit  = v.ab;
    endtask

    task automatic run_vec(input vec_t v, input int tag);
        logic [3:0] eh;
        int         t;
        drive(v);
        @(negedge clk);
        if (v.co) begin
            n_cmp++;
            if (bus.ramout !== v.eo) begin
                n_bad++;
                $display("FAIL ramout vec %0d: got %h want %h", tag, bus.ramout, v.eo);
            end
        end
        exp_q.push_back(v.eh);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        eh = exp_q.pop_front();
        t  = tag_q.pop_front();
        n_cmp++;
        if (bus.flt_hits !== eh) begin
            n_bad++;
            $display("FAIL flt_hits vec %0d: got %0d want %0d", t, bus.flt_hits, eh);
        end
    endtask

    initial begin
        vec_t v;
        int   h;

        // Reset with cs low: output idles at zero, counter cleared.
        v = base(4'd0); v.rst = 1'b1; v.co = 1'b1; v.eo = 8'h00; vecs.push_back(v);
        // Fault-free write/read and deselected output.
        vecs.push_back(wr(6'd3, 8'hA5, 4'd0));
        vecs.push_back(rd(6'd3, 1'b0, 8'h00, 4'd0));
        vecs.push_back(rd(6'd3, 1'b1, 8'hA5, 4'd0));
        v = base(4'd0); v.co = 1'b1; v.eo = 8'h00; vecs.push_back(v);
        vecs.push_back(wr(6'd0, 8'h5A, 4'd0));
        // SA0 @5 bit7: stored 0xFF reads as 0x7F (hit), faulty rewrite stores 0x7F (hit).
        vecs.push_back(wr(6'd5, 8'hFF, 4'd0));
        vecs.push_back(cfg(1'b0, 3'd1, 6'd5, 3'd7, 6'd0, 3'd0, 4'd0));
        vecs.push_back(rd(6'd5, 1'b1, 8'h7F, 4'd1));
        vecs.push_back(wr(6'd5, 8'hFF, 4'd2));
        vecs.push_back(rd(6'd5, 1'b1, 8'h7F, 4'd2));
        vecs.push_back(cfg(1'b0, 3'd0, 6'd0, 3'd0, 6'd0, 3'd0, 4'd2));
        // TF_UP then TF_DN @10 bit0.
        vecs.push_back(cfg(1'b0, 3'd3, 6'd10, 3'd0, 6'd0, 3'd0, 4'd2));
        vecs.push_back(wr(6'd10, 8'h00, 4'd2));
        vecs.push_back(wr(6'd10, 8'h01, 4'd3));
        vecs.push_back(rd(6'd10, 1'b1, 8'h00, 4'd3));
        vecs.push_back(cfg(1'b0, 3'd4, 6'd10, 3'd0, 6'd0, 3'd0, 4'd3));
        vecs.push_back(wr(6'd10, 8'h01, 4'd3));
        vecs.push_back(wr(6'd10, 8'h00, 4'd4));
        vecs.push_back(rd(6'd10, 1'b1, 8'h01, 4'd4));
        vecs.push_back(cfg(1'b0, 3'd0, 6'd0, 3'd0, 6'd0, 3'd0, 4'd4));
        // CFin aggressor (2,b1) victim (40,b4).
        vecs.push_back(wr(6'd40, 8'h00, 4'd4));
        vecs.push_back(wr(6'd2, 8'h00, 4'd4));
        vecs.push_back(cfg(1'b1, 3'd5, 6'd40, 3'd4, 6'd2, 3'd1, 4'd4));
        vecs.push_back(wr(6'd2, 8'h00, 4'd4));
        vecs.push_back(wr(6'd2, 8'h02, 4'd5));
        vecs.push_back(rd(6'd40, 1'b0, 8'h00, 4'd5));
        vecs.push_back(rd(6'd40, 1'b1, 8'h10, 4'd5));
        vecs.push_back(wr(6'd2, 8'h02, 4'd5));
        vecs.push_back(rd(6'd40, 1'b0, 8'h00, 4'd5));
        vecs.push_back(rd(6'd40, 1'b1, 8'h10, 4'd5));
        // Reset coincident with a write and a config write: both suppressed.
        vecs.push_back(wr(6'd7, 8'h11, 4'd5));
        v = wr(6'd7, 8'h33, 4'd0); v.rst = 1'b1; v.cw = 1'b1; v.ty = 3'd2;
        vecs.push_back(v);
        vecs.push_back(rd(6'd0, 1'b1, 8'h5A, 4'd0));
        vecs.push_back(rd(6'd7, 1'b0, 8'h00, 4'd0));
        vecs.push_back(rd(6'd7, 1'b1, 8'h11, 4'd0));
        vecs.push_back(wr(6'd2, 8'h00, 4'd0));
        vecs.push_back(rd(6'd40, 1'b0, 8'h00, 4'd0));
        vecs.push_back(rd(6'd40, 1'b1, 8'h10, 4'd0));
        // Conflicting SA1 (idx0) / SA0 (idx1) on the same bit: higher index wins.
        vecs.push_back(cfg(1'b0, 3'd2, 6'd20, 3'd2, 6'd0, 3'd0, 4'd0));
        vecs.push_back(cfg(1'b1, 3'd1, 6'd20, 3'd2, 6'd0, 3'd0, 4'd0));
        vecs.push_back(wr(6'd20, 8'hFF, 4'd1));
        vecs.push_back(rd(6'd20, 1'b1, 8'hFB, 4'd1));
        // Config in the same cycle as a write: write sees the old table.
        v = wr(6'd21, 8'h01, 4'd1); v.cw = 1'b1; v.ci = 1'b0; v.ty = 3'd1; v.va = 6'd21;
        vecs.push_back(v);
        vecs.push_back(rd(6'd21, 1'b1, 8'h00, 4'd2));

        drive(base(4'd0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        foreach (vecs[i])
            run_vec(vecs[i], i);

        // Saturation: every faulty write to word 20 counts until the counter pins.
        h = 2;
        for (int k = 0; k < 20; k++) begin
            h = (h < 15) ? h + 1 : 15;
            run_vec(wr(6'd20, 8'hFF, 4'(h)), 100 + k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
